// File: rtl/riscv_core_branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, BTB entry
// layout and the saturating counter step.
package riscv_core_pkg;

    localparam int BP_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    // Tag is kept right-aligned in a full-width field (PC shifted down past
    // the index bits), so the layout does not depend on ENTRIES.
    typedef struct packed {
        logic                valid;
        logic [BP_XLEN-1:0]  tag;
        logic [BP_XLEN-1:0]  target;
        bp_ctr_e             ctr;
    } bp_entry_t;

    function automatic bp_ctr_e bp_ctr_next(bp_ctr_e ctr, logic taken);
        case (ctr)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            default: return taken ? ST  : WT;
        endcase
    endfunction

endpackage

// File: rtl/riscv_core_branch_predictor_if.sv
// Fetch-side lookup and execute-side training/redirect signals of the
// branch predictor. The core drives through "master", the predictor is "slave".
interface riscv_core_branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] i_bp_fetch_pc;
    logic            o_bp_predict_taken;
    logic [XLEN-1:0] o_bp_predict_target;

    logic            i_bp_update_valid;
    logic [XLEN-1:0] i_bp_update_pc;
    logic            i_bp_update_compressed;
    logic            i_bp_update_taken;
    logic            i_bp_update_addr_mismatch;
    logic [XLEN-1:0] i_bp_update_target;
    logic            i_bp_update_pred_taken;
    logic [XLEN-1:0] i_bp_update_pred_target;

    logic            o_bp_mispredict;
    logic [XLEN-1:0] o_bp_redirect_pc;
    logic [31:0]     o_bp_mispredict_count;

    modport master (
        output i_bp_fetch_pc,
        input  o_bp_predict_taken, o_bp_predict_target,
        output i_bp_update_valid, i_bp_update_pc, i_bp_update_compressed,
               i_bp_update_taken, i_bp_update_addr_mismatch, i_bp_update_target,
               i_bp_update_pred_taken, i_bp_update_pred_target,
        input  o_bp_mispredict, o_bp_redirect_pc, o_bp_mispredict_count
    );

    modport slave (
        input  i_bp_fetch_pc,
        output o_bp_predict_taken, o_bp_predict_target,
        input  i_bp_update_valid, i_bp_update_pc, i_bp_update_compressed,
               i_bp_update_taken, i_bp_update_addr_mismatch, i_bp_update_target,
               i_bp_update_pred_taken, i_bp_update_pred_target,
        output o_bp_mispredict, o_bp_redirect_pc, o_bp_mispredict_count
    );
endinterface

// File: rtl/riscv_core_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup,
// execute-side training, mispredict detection and redirect PC generation.
module riscv_core_branch_predictor
    import riscv_core_pkg::*;
#(
    parameter int XLEN    = BP_XLEN,
    parameter int ENTRIES = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    riscv_core_branch_predictor_if.slave  bp
);

    localparam int IDXW  = $clog2(ENTRIES);
    localparam int TAGSH = IDXW + 1;

    bp_entry_t       table_q [ENTRIES];
    logic [31:0]     count_q;

    logic [IDXW-1:0] f_idx;
    logic [XLEN-1:0] f_tag;
    logic            f_hit;
    logic [IDXW-1:0] u_idx;
    logic [XLEN-1:0] u_tag;
    logic            u_hit;
    logic            u_active;
    logic            mispredict;
    logic [XLEN-1:0] fall_through;

    // Bit 0 of the PC is always zero for RV32IMC, so indexing starts at bit 1.
    assign f_idx = bp.i_bp_fetch_pc[IDXW:1];
    assign f_tag = bp.i_bp_fetch_pc >> TAGSH;
    assign f_hit = table_q[f_idx].valid && (table_q[f_idx].tag == f_tag);

    assign bp.o_bp_predict_taken  = f_hit && (table_q[f_idx].ctr inside {WT, ST});
    assign bp.o_bp_predict_target = bp.o_bp_predict_taken ? table_q[f_idx].target : '0;

    assign u_idx    = bp.i_bp_update_pc[IDXW:1];
    assign u_tag    = bp.i_bp_update_pc >> TAGSH;
    assign u_hit    = table_q[u_idx].valid && (table_q[u_idx].tag == u_tag);
    assign u_active = bp.i_bp_update_valid && !bp.i_bp_update_addr_mismatch;

    assign mispredict = u_active &&
        ((bp.i_bp_update_taken != bp.i_bp_update_pred_taken) ||
         (bp.i_bp_update_taken && bp.i_bp_update_pred_taken &&
          (bp.i_bp_update_target != bp.i_bp_update_pred_target)));

    assign fall_through = bp.i_bp_update_pc +
                          (bp.i_bp_update_compressed ? XLEN'(2) : XLEN'(4));

    assign bp.o_bp_mispredict       = mispredict;
    assign bp.o_bp_redirect_pc      = !mispredict ? '0 :
                                      bp.i_bp_update_taken ? bp.i_bp_update_target
                                                           : fall_through;
    assign bp.o_bp_mispredict_count = count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
            count_q <= '0;
        end else begin
            if (u_active) begin
                if (u_hit) begin
                    table_q[u_idx].ctr <= bp_ctr_next(table_q[u_idx].ctr, bp.i_bp_update_taken);
                    if (bp.i_bp_update_taken) begin
                        table_q[u_idx].target <= bp.i_bp_update_target;
                    end
                end else if (bp.i_bp_update_taken) begin
                    // Allocation (or replacement of an aliasing entry) starts weakly taken.
                    table_q[u_idx] <= '{valid: 1'b1, tag: u_tag,
                                        target: bp.i_bp_update_target, ctr: WT};
                end
            end
            if (mispredict && (count_q != 32'hFFFF_FFFF)) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Randomized and directed bench for riscv_core_branch_predictor against a
// table-of-integers reference model of the BTB.
module tb_riscv_core_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;

    logic i_clk;
    logic i_rst_n;

    riscv_core_branch_predictor_if #(.XLEN(XLEN)) bus ();

    riscv_core_branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bp      (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] exp_q[$];

    // reference model: one slot per index, counter kept as an int 0..3
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_count;

    logic        obs_pt, obs_mp;
    logic [31:0] obs_ptgt, obs_redir, obs_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (2 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_count = '0;
    endtask

    task automatic idle_inputs();
        bus.i_bp_fetch_pc             = '0;
        bus.i_bp_update_valid         = 1'b0;
        bus.i_bp_update_pc            = '0;
        bus.i_bp_update_compressed    = 1'b0;
        bus.i_bp_update_taken         = 1'b0;
        bus.i_bp_update_addr_mismatch = 1'b0;
        bus.i_bp_update_target        = '0;
        bus.i_bp_update_pred_taken    = 1'b0;
        bus.i_bp_update_pred_target   = '0;
    endtask

    // One cycle: apply inputs after a falling edge, check combinational
    // outputs, then let the rising edge commit and advance the model.
    task automatic drive(input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                         input bit comp, input bit tk, input bit mism,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        bit          e_pt, e_mp, act, hit;
        logic [31:0] e_ptgt, e_redir;
        int          ui;
        bus.i_bp_fetch_pc             = fpc;
        bus.i_bp_update_valid         = uv;
        bus.i_bp_update_pc            = upc;
        bus.i_bp_update_compressed    = comp;
        bus.i_bp_update_taken         = tk;
        bus.i_bp_update_addr_mismatch = mism;
        bus.i_bp_update_target        = tgt;
        bus.i_bp_update_pred_taken    = ptk;
        bus.i_bp_update_pred_target   = ptgt;
        #1;
        e_pt    = m_pred(fpc);
        e_ptgt  = e_pt ? m_tgt[idx_of(fpc)] : 32'h0;
        act     = uv && !mism;
        e_mp    = act && ((tk != ptk) || (tk && ptgt != tgt));
        e_redir = !e_mp ? 32'h0 : tk ? tgt : upc + (comp ? 32'd2 : 32'd4);
        obs_pt    = bus.o_bp_predict_taken;
        obs_ptgt  = bus.o_bp_predict_target;
        obs_mp    = bus.o_bp_mispredict;
        obs_redir = bus.o_bp_redirect_pc;
        obs_cnt   = bus.o_bp_mispredict_count;
        check_eq("predict_taken", obs_pt, e_pt);
        check_eq("predict_target", obs_ptgt, e_ptgt);
        check_eq("mispredict", obs_mp, e_mp);
        exp_q.push_back(e_redir);
        check_eq("redirect_pc", obs_redir, exp_q.pop_front());
        check_eq("mispredict_count", obs_cnt, m_count);
        @(posedge i_clk);
        ui  = idx_of(upc);
        hit = m_hit(upc);
        if (act) begin
            if (hit) begin
                m_ctr[ui] = tk ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                               : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
                if (tk) m_tgt[ui] = tgt;
            end else if (tk) begin
                m_valid[ui] = 1;
                m_tag[ui]   = tag_of(upc);
                m_tgt[ui]   = tgt;
                m_ctr[ui]   = 2;
            end
        end
        if (e_mp && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        @(negedge i_clk);
    endtask

    task automatic lookup(input logic [31:0] fpc);
        drive(fpc, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt, input bit comp);
        drive(pc, 1, pc, comp, tk, 0, tgt, ptk, ptgt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pc, tgt, ptgt;
        bit          tk, ptk;
        model_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;

        // reset state and cold miss
        lookup(32'h100);
        check_eq("cold_pt", obs_pt, 0);
        check_eq("cold_ptgt", obs_ptgt, 32'h0);
        train(32'h100, 0, 32'h0, 0, 32'h0, 0);
        check_eq("nt_miss_mp", obs_mp, 0);
        lookup(32'h100);
        check_eq("no_alloc_pt", obs_pt, 0);

        // allocate and train
        train(32'h100, 1, 32'h80, 0, 32'h0, 0);
        check_eq("alloc_mp", obs_mp, 1);
        check_eq("alloc_redir", obs_redir, 32'h80);
        lookup(32'h100);
        check_eq("alloc_pt", obs_pt, 1);
        check_eq("alloc_ptgt", obs_ptgt, 32'h80);
        check_eq("alloc_cnt", obs_cnt, 1);
        repeat (3) train(32'h100, 1, 32'h80, 1, 32'h80, 0);
        train(32'h100, 0, 32'h0, 1, 32'h80, 0);
        lookup(32'h100);
        check_eq("st_to_wt_pt", obs_pt, 1);

        // fall-through redirects
        train(32'h100, 0, 32'h0, 1, 32'h80, 1);
        check_eq("ft_c_redir", obs_redir, 32'h102);
        train(32'h100, 0, 32'h0, 1, 32'h80, 0);
        check_eq("ft_n_redir", obs_redir, 32'h104);
        lookup(32'h100);
        check_eq("nt_trained_pt", obs_pt, 0);

        // aliasing: 0x100 and 0x140 share index 0
        repeat (2) train(32'h100, 1, 32'h80, 0, 32'h0, 0);
        train(32'h140, 1, 32'h200, 1, 32'h80, 0);
        check_eq("alias_mp", obs_mp, 1);
        check_eq("alias_redir", obs_redir, 32'h200);
        lookup(32'h100);
        check_eq("alias_evict_pt", obs_pt, 0);

        // misalignment: no write, no count
        drive(32'h200, 1, 32'h200, 0, 1, 1, 32'h300, 0, 32'h0);
        check_eq("mism_mp", obs_mp, 0);
        lookup(32'h200);
        check_eq("mism_nowrite_pt", obs_pt, 0);

        // same-cycle lookup and write on index 3 sees old contents
        drive(32'h006, 1, 32'h006, 0, 1, 0, 32'h300, 0, 32'h0);
        check_eq("collide_old_pt", obs_pt, 0);
        lookup(32'h006);
        check_eq("collide_new_ptgt", obs_ptgt, 32'h300);

        // randomized traffic over a small PC pool so entries hit and alias
        for (int n = 0; n < 400; n++) begin
            pc   = (32'(8 + $urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 15)) << 1);
            tk   = ($urandom_range(0, 2) != 0);
            tgt  = ($urandom_range(0, 1) != 0) ? 32'h80 : ($urandom & 32'hFFFF_FFFE);
            if ($urandom_range(0, 1) != 0) begin
                ptk  = m_pred(pc);
                ptgt = ptk ? m_tgt[idx_of(pc)] : 32'h0;
            end else begin
                ptk  = $urandom_range(0, 1) != 0;
                ptgt = ($urandom_range(0, 1) != 0) ? tgt : 32'h80;
            end
            drive((32'(8 + $urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 15)) << 1),
                  $urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) != 0, tk,
                  $urandom_range(0, 7) == 0, tgt, ptk, ptgt);
        end

        // asynchronous reset between edges with a trained entry in place
        train(32'h006, 1, 32'h300, 0, 32'h0, 0);
        bus.i_bp_fetch_pc = 32'h006;
        #1;
        check_eq("pre_rst_pt", bus.o_bp_predict_taken, 1);
        #2;
        i_rst_n = 1'b0;
        bus.i_bp_update_valid       = 1'b1;
        bus.i_bp_update_pc          = 32'h010;
        bus.i_bp_update_taken       = 1'b1;
        bus.i_bp_update_target      = 32'h440;
        bus.i_bp_update_pred_taken  = 1'b0;
        #1;
        check_eq("rst_pt", bus.o_bp_predict_taken, 0);
        check_eq("rst_ptgt", bus.o_bp_predict_target, 32'h0);
        check_eq("rst_cnt", bus.o_bp_mispredict_count, 32'h0);
        check_eq("rst_mp", bus.o_bp_mispredict, 1);
        check_eq("rst_redir", bus.o_bp_redirect_pc, 32'h440);
        @(negedge i_clk);
        idle_inputs();
        model_reset();
        i_rst_n = 1'b1;
        lookup(32'h006);
        lookup(32'h010);

        // counter saturation
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFE;
        @(negedge i_clk);
        train(32'h020, 1, 32'h500, 0, 32'h0, 0);
        train(32'h030, 1, 32'h600, 0, 32'h0, 0);
        check_eq("sat_reach", obs_cnt, 32'hFFFF_FFFF);
        lookup(32'h020);
        check_eq("sat_hold", obs_cnt, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/riscv_core_branch_predictor.md
# riscv_core_branch_predictor

- Dynamic branch predictor for the RV32IMC 5-stage core.
- Two sides:
  - **Fetch side:** looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Returns a taken prediction and a target.
  - **Execute side:** consumes the resolved outcome from the execute-stage branch unit. Trains the table, flags a mispredict and supplies the redirect PC to the fetch/flush logic.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- ENTRIES, 16, BTB entries; power of 2, ≥2; IDXW = $clog2(ENTRIES)

Ports:
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_bp_fetch_pc  in  XLEN  fetch-stage PC
- o_bp_predict_taken  out  1  predict taken for i_bp_fetch_pc
- o_bp_predict_target  out  XLEN  predicted target; valid when o_bp_predict_taken=1, else 0
- i_bp_update_valid  in  1  resolved conditional branch present in execute this cycle
- i_bp_update_pc  in  XLEN  PC of that branch
- i_bp_update_compressed  in  1  branch is a 16-bit instruction
- i_bp_update_taken  in  1  branch-unit istaken
- i_bp_update_addr_mismatch  in  1  branch-unit target misalignment flag
- i_bp_update_target  in  XLEN  computed branch target
- i_bp_update_pred_taken  in  1  prediction made for this branch at fetch, piped down
- i_bp_update_pred_target  in  XLEN  predicted target piped down
- o_bp_mispredict  out  1  flush younger stages and redirect fetch
- o_bp_redirect_pc  out  XLEN  correct next PC when o_bp_mispredict=1, else 0
- o_bp_mispredict_count  out  32  saturating mispredict counter

## Operation
- **Indexing:** PC bit 0 ignored (halfword alignment).
  - index = pc[IDXW:1]
  - tag = pc[XLEN-1:IDXW+1]
- **Entry contents:** valid, tag, target[XLEN-1:0], ctr[1:0] (00 SNT, 01 WNT, 10 WT, 11 ST).
- **Lookup:** combinational from registered state.
  - hit = valid && tag match.
  - o_bp_predict_taken = hit && ctr[1].
- **Update:** active only when i_bp_update_valid=1 and i_bp_update_addr_mismatch=0.
  - Hit, taken: ctr saturating +1; target <= i_bp_update_target.
  - Hit, not taken: ctr saturating −1; target unchanged; valid stays 1.
  - Miss, taken: allocate/replace; valid=1, tag, target written, ctr=10.
  - Miss, not taken: no write.
- **Mispredict:** o_bp_mispredict = update active && ((taken ≠ pred_taken) || (taken && pred_taken && target ≠ pred_target)).
- **Redirect PC:**
  - taken → i_bp_update_target
  - not taken → i_bp_update_pc + (compressed ? 2 : 4), modulo 2^XLEN
- **addr_mismatch=1:** no table write, o_bp_mispredict=0, counter unchanged. The trap path owns this case.
- **o_bp_mispredict_count:** +1 per cycle with o_bp_mispredict=1; saturates at 32'hFFFF_FFFF.

## Timing
- Lookup and mispredict/redirect are combinational: zero latency, same cycle as inputs.
- Table writes and the counter update on the rising i_clk edge after an active update. They are visible to lookup the following cycle.
- Simultaneous lookup and update on the same index: lookup returns pre-update contents.
- Back-to-back updates to the same entry in consecutive cycles: each applies to the result of the previous one (no lost updates).
- **Reset (any time, including mid-update), asynchronous:**
  - all valid=0, all ctr=01, targets/tags=0, count=0
  - therefore o_bp_predict_taken=0, o_bp_predict_target=0
  - o_bp_mispredict depends only on the update inputs; o_bp_redirect_pc=0 when o_bp_mispredict=0
- Release of reset is synchronous to i_clk; the first update is accepted on the first edge after deassertion.

## Structure
- riscv_core_pkg holds:
  - bp_ctr_e enum (SNT/WNT/WT/ST)
  - bp_entry_t struct {valid, tag, target, ctr}
  - function bp_ctr_next(ctr, taken) for saturating update
- Table is an unpacked array of bp_entry_t in flops (no SRAM macro): needs single-cycle async reset and combinational read.
- No sub-module; a single module is natural.

## Test plan
1. **Reset/cold miss.** After reset, fetch_pc=0x0000_0100 → predict_taken=0, target=0. Update pc=0x100, taken=0, pred_taken=0 → mispredict=0, no allocation (next lookup still 0).
2. **Allocate and train.** Update pc=0x100, taken=1, target=0x80, pred_taken=0 → mispredict=1, redirect=0x80, count=1. Next cycle lookup 0x100 → taken=1, target=0x80. Three more taken updates → ctr=11. One not-taken → ctr=10, still predict taken.
3. **Fall-through redirect.** With 0x100 at ctr=10, update taken=0, pred_taken=1, compressed=1 → mispredict=1, redirect=0x102. Same with compressed=0 → 0x104. After a second not-taken, lookup predicts not taken.
4. **Wrong target/aliasing.** ENTRIES=16: pc 0x100 and 0x140 share index 0 with different tags. Train 0x100 taken→0x80, then update 0x140 taken→0x200 with pred_taken=1, pred_target=0x80 → mispredict=1, redirect=0x200. Lookup 0x100 now misses.
5. **Misalignment and collision.** Update taken=1, addr_mismatch=1 → mispredict=0, no write, count unchanged. In the same cycle as a write to index 3, lookup index 3 returns old data.
6. **Reset mid-operation.** Assert i_rst_n=0 between clock edges with trained entries → predict_taken drops to 0 immediately, count=0. Counter saturation check: force count to 0xFFFF_FFFF, mispredict → stays 0xFFFF_FFFF.
